// File: rtl/decode_stage.sv
// RISC-V decode stage: field extraction, immediate generation and illegal-encoding detection behind a two-entry skid buffer.
// Optional M-extension acceptance is enabled by defining BRISCV_M_EXT_EN.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_rd_we,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_we;
    logic            illegal;
  } beat_t;

  beat_t dec;
  beat_t out_q, out_d, skid_q, skid_d;
  logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  logic [2:0]        fmt_raw;
  logic              bad;
  logic              m_op, m_op32;
  logic signed [31:0] imm32;

  always_comb begin
    dec        = '0;
    fmt_raw    = FMT_ILL;
    bad        = 1'b0;
    imm32      = '0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.funct3 = in_instr[14:12];
    dec.funct7 = in_instr[31:25];

`ifdef BRISCV_M_EXT_EN
    m_op   = (dec.funct7 == 7'h01);
    m_op32 = (dec.funct7 == 7'h01) && ((dec.funct3 == 3'b000) || dec.funct3[2]);
`else
    m_op   = 1'b0;
    m_op32 = 1'b0;
`endif

    case (dec.opcode)
      OPC_LUI, OPC_AUIPC:       fmt_raw = FMT_U;
      OPC_JAL:                  fmt_raw = FMT_J;
      OPC_MISC_MEM, OPC_SYSTEM: fmt_raw = FMT_I;
      OPC_JALR: begin
        fmt_raw = FMT_I;
        bad     = (dec.funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt_raw = FMT_B;
        bad     = (dec.funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        fmt_raw = FMT_I;
        bad     = (dec.funct3 == 3'b111) ||
                  ((XLEN == 32) && ((dec.funct3 == 3'b011) || (dec.funct3 == 3'b110)));
      end
      OPC_STORE: begin
        fmt_raw = FMT_S;
        bad     = dec.funct3[2] || ((XLEN == 32) && (dec.funct3 == 3'b011));
      end
      OPC_OP_IMM: begin
        fmt_raw = FMT_I;
        // RV64 shamt takes bit 25, so only instr[31:26] qualifies the shift kind there
        if (dec.funct3[1:0] == 2'b01) begin
          if (XLEN == 32)
            bad = !((dec.funct7 == 7'h00) || (dec.funct7 == 7'h20));
          else
            bad = !((in_instr[31:26] == 6'h00) || (in_instr[31:26] == 6'h10));
        end
      end
      OPC_OP: begin
        fmt_raw = FMT_R;
        bad     = ((dec.funct7 == 7'h20) && !((dec.funct3 == 3'b000) || (dec.funct3 == 3'b101))) ||
                  !((dec.funct7 == 7'h00) || (dec.funct7 == 7'h20) || m_op);
      end
      OPC_OP_IMM32: begin
        if (XLEN == 64) begin
          fmt_raw = FMT_I;
          if (dec.funct3[1:0] == 2'b01)
            bad = !((dec.funct7 == 7'h00) || (dec.funct7 == 7'h20));
        end
      end
      OPC_OP32: begin
        if (XLEN == 64) begin
          fmt_raw = FMT_R;
          bad     = ((dec.funct7 == 7'h20) && !((dec.funct3 == 3'b000) || (dec.funct3 == 3'b101))) ||
                    !((dec.funct7 == 7'h00) || (dec.funct7 == 7'h20) || m_op32);
        end
      end
      default: fmt_raw = FMT_ILL;
    endcase

    dec.illegal = (fmt_raw == FMT_ILL) || bad || (in_instr[1:0] != 2'b11);
    dec.fmt     = dec.illegal ? FMT_ILL : fmt_raw;

    case (dec.fmt)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_J: imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm = XLEN'(imm32);

    dec.rs1_en = (dec.fmt == FMT_R) || (dec.fmt == FMT_I) || (dec.fmt == FMT_S) || (dec.fmt == FMT_B);
    dec.rs2_en = (dec.fmt == FMT_R) || (dec.fmt == FMT_S) || (dec.fmt == FMT_B);
    dec.rd_we  = ((dec.fmt == FMT_R) || (dec.fmt == FMT_I) || (dec.fmt == FMT_U) || (dec.fmt == FMT_J)) &&
                 (dec.rd != 5'd0) &&
                 !((dec.opcode == OPC_SYSTEM) && (dec.funct3 == 3'b000));
  end

  logic accept;
  assign in_ready = !rst && !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // output register is free this edge: refill from skid first to keep order
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_opcode  = out_q.opcode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_rs1_en  = out_q.rs1_en;
  assign out_rs2_en  = out_q.rs2_en;
  assign out_rd_we   = out_q.rd_we;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        in_ready_32, out_valid_32, rs1_en_32, rs2_en_32, rd_we_32, illegal_32;
  logic [31:0] pc_32, imm_32;
  logic [6:0]  opcode_32, funct7_32;
  logic [4:0]  rd_32, rs1_32, rs2_32;
  logic [2:0]  funct3_32, fmt_32;

  logic        in_ready_64, out_valid_64, rs1_en_64, rs2_en_64, rd_we_64, illegal_64;
  logic [31:0] pc_64;
  logic [63:0] imm_64;
  logic [6:0]  opcode_64, funct7_64;
  logic [4:0]  rd_64, rs1_64, rs2_64;
  logic [2:0]  funct3_64, fmt_64;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid_32), .out_ready(out_ready), .out_pc(pc_32),
    .out_opcode(opcode_32), .out_rd(rd_32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_funct3(funct3_32), .out_funct7(funct7_32), .out_imm(imm_32), .out_fmt(fmt_32),
    .out_rs1_en(rs1_en_32), .out_rs2_en(rs2_en_32), .out_rd_we(rd_we_32),
    .out_illegal(illegal_32)
  );

  decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid_64), .out_ready(out_ready), .out_pc(pc_64),
    .out_opcode(opcode_64), .out_rd(rd_64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_funct3(funct3_64), .out_funct7(funct7_64), .out_imm(imm_64), .out_fmt(fmt_64),
    .out_rs1_en(rs1_en_64), .out_rs2_en(rs2_en_64), .out_rd_we(rd_we_64),
    .out_illegal(illegal_64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // advance one clock; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
    $display("txn t=%0t in_v=%0b instr=%08h rdy=%0b out_v=%0b out_pc=%08h fmt=%0d ill=%0b",
             $time, in_valid, in_instr, in_ready_32, out_valid_32, pc_32, fmt_32, illegal_32);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    step();
    check("rst_out_valid", 64'(out_valid_32), 64'd0);
    check("rst_out_pc",    64'(pc_32), 64'd0);
    check("rst_imm64",     imm_64, 64'd0);
    check("rst_fmt",       64'(fmt_32), 64'd0);
    check("rst_in_ready",  64'(in_ready_32), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready_32), 64'd1);

    // addi x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h100);
    step();
    check("addi_valid",  64'(out_valid_32), 64'd1);
    check("addi_pc",     64'(pc_32), 64'h100);
    check("addi_fmt",    64'(fmt_32), 64'd1);
    check("addi_rd",     64'(rd_32), 64'd1);
    check("addi_rs1_en", 64'(rs1_en_32), 64'd1);
    check("addi_rd_we",  64'(rd_we_32), 64'd1);
    check("addi_imm32",  64'(imm_32), 64'hFFFFFFFF);
    check("addi_imm64",  imm_64, 64'hFFFFFFFFFFFFFFFF);

    // beq x0,x0,-4
    drive(1'b1, 32'hFE000EE3, 32'h104);
    step();
    check("beq_fmt",    64'(fmt_32), 64'd3);
    check("beq_imm",    64'(imm_32), 64'hFFFFFFFC);
    check("beq_rd_we",  64'(rd_we_32), 64'd0);
    check("beq_rs2_en", 64'(rs2_en_32), 64'd1);
    check("beq_rd_raw", 64'(rd_32), 64'd29);

    drive(1'b1, 32'h123452B7, 32'h108);
    step();
    check("lui_imm64", imm_64, 64'h0000000012345000);
    check("lui_fmt",   64'(fmt_64), 64'd4);
    check("lui_rs1_en", 64'(rs1_en_64), 64'd0);

    drive(1'b1, 32'h800002B7, 32'h10C);
    step();
    check("lui_neg_imm64", imm_64, 64'hFFFFFFFF80000000);
    check("lui_neg_imm32", 64'(imm_32), 64'h80000000);

    // ld: RV64 only
    drive(1'b1, 32'h00003003, 32'h110);
    step();
    check("ld_ill64",  64'(illegal_64), 64'd0);
    check("ld_fmt64",  64'(fmt_64), 64'd1);
    check("ld_ill32",  64'(illegal_32), 64'd1);
    check("ld_fmt32",  64'(fmt_32), 64'd7);
    check("ld_raw_f3", 64'(funct3_32), 64'd3);

    drive(1'b0, 32'h0, 32'h0);
    step();
    check("idle_valid", 64'(out_valid_32), 64'd0);

    // backpressure: A and B fill the buffer, C waits
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h200);
    step();
    check("bp_A_in_ready", 64'(in_ready_32), 64'd1);
    drive(1'b1, 32'h00200093, 32'h204);
    step();
    check("bp_full_in_ready", 64'(in_ready_32), 64'd0);
    drive(1'b1, 32'h00300093, 32'h208);
    step();
    check("bp_stall_pc",       64'(pc_32), 64'h200);
    check("bp_stall_in_ready", 64'(in_ready_64), 64'd0);
    out_ready = 1'b1;
    #1;
    check("bp_emit_A", 64'(pc_32), 64'h200);
    step();
    check("bp_emit_B", 64'(pc_32), 64'h204);
    check("bp_B_imm",  64'(imm_32), 64'd2);
    check("bp_drain_in_ready", 64'(in_ready_32), 64'd1);
    step();
    check("bp_emit_C", 64'(pc_32), 64'h208);
    check("bp_C_valid", 64'(out_valid_32), 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("bp_empty", 64'(out_valid_32), 64'd0);

    // flush while FULL with a beat on the input
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h300);
    step();
    drive(1'b1, 32'h00200093, 32'h304);
    step();
    check("fl_full_in_ready", 64'(in_ready_32), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00300093, 32'h308);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_out_valid", 64'(out_valid_32), 64'd0);
    check("fl_in_ready",  64'(in_ready_32), 64'd1);
    out_ready = 1'b1;
    step();
    check("fl_no_emit", 64'(out_valid_32), 64'd0);

    // mul x0,x1,x2
    drive(1'b1, 32'h02208033, 32'h400);
    step();
`ifdef BRISCV_M_EXT_EN
    check("mul_fmt",     64'(fmt_32), 64'd0);
    check("mul_illegal", 64'(illegal_32), 64'd0);
    check("mul_rs2_en",  64'(rs2_en_32), 64'd1);
`else
    check("mul_fmt",     64'(fmt_32), 64'd7);
    check("mul_illegal", 64'(illegal_32), 64'd1);
    check("mul_rs2_en",  64'(rs2_en_32), 64'd0);
`endif
    check("mul_rd_we",  64'(rd_we_32), 64'd0);
    check("mul_funct7", 64'(funct7_32), 64'h01);

    drive(1'b1, 32'h00000000, 32'h404);
    step();
    check("zero_illegal32", 64'(illegal_32), 64'd1);
    check("zero_illegal64", 64'(illegal_64), 64'd1);
    check("zero_imm",       64'(imm_32), 64'd0);

    // sub is legal, funct7 0x20 with funct3 001 is not
    drive(1'b1, 32'h40208033, 32'h408);
    step();
    check("sub_fmt", 64'(fmt_32), 64'd0);
    drive(1'b1, 32'h40209033, 32'h40C);
    step();
    check("bad_sll_illegal", 64'(illegal_32), 64'd1);

    // reset mid-stall discards both entries
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h500);
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_stall_valid", 64'(out_valid_32), 64'd0);
    check("rst_stall_pc",    64'(pc_32), 64'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    check("rst_stall_no_emit", 64'(out_valid_32), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised RISC-V instruction decode stage that sits between fetch and register-read/execute. It accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake. It extracts register and function fields, generates the format-correct sign-extended immediate at XLEN width, and flags illegal encodings. A two-entry skid buffer gives full throughput under backpressure, and a flush input discards in-flight beats on branch redirect or trap.

## Interface
- `XLEN`, default 32: datapath width; legal values 32 or 64.
- `PC_W`, default 32: PC width carried alongside the instruction.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: fetch beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_instr` in 32: raw instruction.
- `in_pc` in PC_W: instruction address.
- `flush` in 1: synchronous discard of all held and incoming beats.
- `out_valid` out 1: decoded beat valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_pc` out PC_W: PC of the decoded beat.
- `out_opcode` out 7: instr[6:0].
- `out_rd` out 5: instr[11:7].
- `out_rs1` out 5: instr[19:15].
- `out_rs2` out 5: instr[24:20].
- `out_funct3` out 3: instr[14:12].
- `out_funct7` out 7: instr[31:25].
- `out_imm` out XLEN: sign-extended immediate.
- `out_fmt` out 3: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
- `out_rs1_en` out 1: rs1 is read.
- `out_rs2_en` out 1: rs2 is read.
- `out_rd_we` out 1: rd is written; forced 0 when rd=0.
- `out_illegal` out 1: encoding illegal.

## Operation
- Decode is combinational on `in_instr`. The result is captured into the output register, or into the skid register when the output register is stalled.
- Immediates (s = instr[31], sign-extended to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {s, instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31.
  - J: {s, instr[19:12], instr[20], instr[30:21], 0}.
  - R: 0.
- Opcode to format:
  - LUI and AUIPC: U.
  - JAL: J.
  - JALR, LOAD, OP-IMM, MISC-MEM, SYSTEM: I.
  - STORE: S.
  - BRANCH: B.
  - OP: R.
  - When XLEN=64, OP-IMM-32 is I and OP-32 is R.
- Illegal when any of the following holds:
  - instr[1:0] ≠ 11, or the opcode is unlisted.
  - JALR with funct3 ≠ 0.
  - BRANCH with funct3 010 or 011.
  - LOAD with funct3 111, or funct3 011/110 when XLEN=32.
  - STORE with funct3 ≥ 100, or funct3 011 when XLEN=32.
  - Shift-immediate upper bits not 0x00/0x20. The field checked is instr[31:25] when XLEN=32 and instr[31:26] when XLEN=64.
  - OP with funct7 0x20 and funct3 ∉ {000, 101}.
  - OP with funct7 not in {0x00, 0x20}, except as allowed under Configuration.
- On an illegal beat:
  - `out_fmt` = 7, `out_imm` = 0, and all enables are 0.
  - Raw fields still pass through.
- Enables:
  - rs1_en for R, I, S, B, except LUI, AUIPC, JAL.
  - rs2_en for R, S, B.
  - rd_we for R, I, U, J with rd ≠ 0.
  - SYSTEM writes rd only when funct3 ≠ 0.
- Buffer states are EMPTY, ONE (output register valid), and FULL (output register and skid valid).
  - `in_ready` = !rst & !skid_valid.
  - EMPTY→ONE on accept.
  - ONE→FULL on accept while `out_ready`=0.
  - FULL→ONE when `out_ready`=1: the skid entry moves to the output register.
  - ONE→EMPTY when `out_ready`=1 and no accept.
  - In ONE, simultaneous accept and `out_ready` keeps ONE with the new beat.
- Order is always preserved.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput is 1 beat per cycle while `out_ready`=1.
- Output data is stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` falls the cycle after the buffer enters FULL. It rises the cycle after the skid entry drains.
- `flush` (priority over all else): at the edge it is sampled, the output and skid valids clear and any same-cycle incoming beat is dropped. `in_ready`=1 the next cycle.
- `rst`: at the sampling edge, all valids and every output register clear to 0; `in_ready`=0 while `rst`=1. Reset mid-stall discards both entries.

## Configuration
- `BRISCV_M_EXT_EN` defined: OP with funct7 0x01 is legal (M extension) with fmt R. When XLEN=64, OP-32 with funct7 0x01 and funct3 ∈ {000, 100–111} is also legal.
- `BRISCV_M_EXT_EN` undefined: funct7 0x01 is illegal.

## Test plan
- Assert `rst` for 2 cycles → `out_valid`=0, all outputs 0, `in_ready`=0. After release, `in_ready`=1.
- 0xFFF00093 (addi x1,x0,-1) → next cycle: fmt=1, rd=1, rs1_en=1, rd_we=1, imm=0xFFFFFFFF. Then 0xFE000EE3 (beq x0,x0,-4) → fmt=3, imm=0xFFFFFFFC, rd_we=0, rs2_en=1.
- XLEN=64:
  - 0x123452B7 → imm 0x0000000012345000.
  - 0x800002B7 → imm 0xFFFFFFFF80000000.
  - 0x00003003 (ld) → legal; the same beat at XLEN=32 → illegal=1.
- Hold `out_ready`=0 and offer beats A, B, C → A and B accepted, `in_ready`=0 from the cycle after B. Release → A, B, C emerge on consecutive cycles.
- Stall in FULL, then pulse `flush` with `in_valid`=1 → `out_valid`=0 next cycle, no beat emerges, `in_ready`=1.
- 0x02208033 (mul x0,x1,x2) → with `BRISCV_M_EXT_EN`: fmt=0, illegal=0, rd_we=0. Without it: illegal=1, fmt=7. 0x00000000 → illegal=1 in both builds.
